// File: rtl/mem_req_bridge.sv
// Queues CPU load/store requests in a 2-entry FIFO and issues them one at a time to the SDRAM
// controller. Define MEM_BRIDGE_TIMEOUT_EN to abort accesses that wait TIMEOUT cycles.
module mem_req_bridge #(
    parameter int unsigned N       = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_valid,
    output logic         cpu_ready,
    input  logic         cpu_we,
    input  logic [17:0]  cpu_addr,
    input  logic [N-1:0] cpu_wdata,
    output logic         cpu_done,
    output logic         cpu_rvalid,
    output logic         cpu_err,
    output logic [N-1:0] cpu_rdata,
    output logic [1:0]   op,
    output logic [17:0]  dataAddr,
    output logic [N-1:0] dataWrite,
    input  logic [N-1:0] dataRead,
    input  logic         readReady
);
    localparam logic [1:0] OpIdle  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpRead  = 2'b10;

    typedef enum logic [1:0] {StIdle, StBusy, StRecover} state_e;

    logic         fifo_we_q    [2];
    logic [17:0]  fifo_addr_q  [2];
    logic [N-1:0] fifo_wdata_q [2];
    logic         fifo_mis_q   [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   count_q;
    logic         push, pop;

    state_e       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [17:0]  addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] rdata_q, rdata_d;
    logic         done_q, done_d;
    logic         rvalid_q, rvalid_d;
    logic         err_q, err_d;
    logic         timeout;

    assign cpu_ready = ~reset & (count_q != 2'd2);
    assign push      = cpu_valid & cpu_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we_q[wr_ptr_q]    <= cpu_we;
            fifo_addr_q[wr_ptr_q]  <= cpu_addr;
            fifo_wdata_q[wr_ptr_q] <= cpu_wdata;
            fifo_mis_q[wr_ptr_q]   <= |cpu_addr[2:0];
        end
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic [7:0] tcnt_q, tcnt_d;

    assign timeout = (tcnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == StIdle) begin
            tcnt_d = 8'd0;
        end else if (state_q == StBusy) begin
            tcnt_d = tcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) tcnt_q <= 8'd0;
        else       tcnt_q <= tcnt_d;
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != 2'd0) begin
                    if (fifo_mis_q[rd_ptr_q]) begin
                        pop     = 1'b1;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = StRecover;
                    end else begin
                        op_d    = fifo_we_q[rd_ptr_q] ? OpWrite : OpRead;
                        addr_d  = fifo_addr_q[rd_ptr_q];
                        wdata_d = fifo_wdata_q[rd_ptr_q];
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (readReady) begin
                    pop     = 1'b1;
                    op_d    = OpIdle;
                    done_d  = 1'b1;
                    state_d = StRecover;
                    if (op_q == OpRead) begin
                        rvalid_d = 1'b1;
                        rdata_d  = dataRead;
                    end
                end else if (timeout) begin
                    pop     = 1'b1;
                    op_d    = OpIdle;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StRecover;
                end
            end
            StRecover: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= OpIdle;
            addr_q   <= 18'd0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign op         = op_q;
    assign dataAddr   = addr_q;
    assign dataWrite  = wdata_q;
    assign cpu_done   = done_q;
    assign cpu_rvalid = rvalid_q;
    assign cpu_err    = err_q;
    assign cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_req_bridge.sv
// Bench for mem_req_bridge: directed scenarios plus random traffic against a controller model
// and an in-order request scoreboard.
module tb_mem_req_bridge;
    localparam int unsigned N  = 64;
    localparam int unsigned TO = 8;

    typedef struct packed {
        logic        we;
        logic [17:0] addr;
        logic [63:0] wd;
    } req_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_valid, cpu_ready, cpu_we;
    logic [17:0]  cpu_addr;
    logic [N-1:0] cpu_wdata;
    logic         cpu_done, cpu_rvalid, cpu_err;
    logic [N-1:0] cpu_rdata;
    logic [1:0]   op;
    logic [17:0]  dataAddr;
    logic [N-1:0] dataWrite;
    logic [N-1:0] dataRead  = '0;
    logic         readReady = 1'b0;

    int total = 0;
    int bad   = 0;

    // controller model state
    bit          ctrl_en   = 1'b0;
    int          ctrl_lat  = 0;
    int          lat_cnt   = 0;
    bit          resp_sent = 1'b0;
    logic [63:0] cmem [logic [17:0]];

    req_t        exp_q [$];
    logic [63:0] rmem [logic [17:0]];

    always #5 clk = ~clk;

    mem_req_bridge #(.N(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_done   (cpu_done),
        .cpu_rvalid (cpu_rvalid),
        .cpu_err    (cpu_err),
        .cpu_rdata  (cpu_rdata),
        .op         (op),
        .dataAddr   (dataAddr),
        .dataWrite  (dataWrite),
        .dataRead   (dataRead),
        .readReady  (readReady)
    );

    function automatic logic [63:0] dflt(input logic [17:0] a);
        return 64'h9E37_79B9_7F4A_7C15 ^ {46'd0, a};
    endfunction

    // Controller: completes each access ctrl_lat cycles after op appears, one readReady pulse.
    always @(negedge clk) begin
        readReady = 1'b0;
        if (op == 2'b00) begin
            lat_cnt   = 0;
            resp_sent = 1'b0;
        end else if (ctrl_en && !resp_sent) begin
            if (lat_cnt >= ctrl_lat) begin
                readReady = 1'b1;
                resp_sent = 1'b1;
                if (op == 2'b10) begin
                    dataRead = cmem.exists(dataAddr) ? cmem[dataAddr] : dflt(dataAddr);
                end else begin
                    cmem[dataAddr] = dataWrite;
                    dataRead       = {$urandom, $urandom};
                end
            end else begin
                lat_cnt++;
            end
        end
    end

    task automatic send(input logic we, input logic [17:0] a, input logic [63:0] wd);
        int n = 0;
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        while (cpu_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL send_accept addr=%h ready=%b want=1", a, cpu_ready);
        end
        @(negedge clk);
        cpu_valid = 1'b0;
    endtask

    task automatic wait_done(output bit found);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cpu_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge clk);
        total++;
        if (cpu_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b want=0", cpu_ready);
        end
        total++;
        if ({op, dataAddr, dataWrite} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl op=%b addr=%h wdata=%h want=0", op, dataAddr, dataWrite);
        end
        total++;
        if ({cpu_done, cpu_rvalid, cpu_err, cpu_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_resp done=%b rvalid=%b err=%b rdata=%h want=0",
                     cpu_done, cpu_rvalid, cpu_err, cpu_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b want=1", cpu_ready);
        end
    endtask

    task automatic test_load();
        bit found;
        cmem[18'h00100] = 64'h1122334455667788;
        ctrl_en  = 1'b1;
        ctrl_lat = 3;
        send(1'b0, 18'h00100, 64'd0);
        total++;
        if (op !== 2'b00) begin
            bad++;
            $display("FAIL load_op_early got=%b want=00", op);
        end
        @(negedge clk);
        total++;
        if (op !== 2'b10 || dataAddr !== 18'h00100) begin
            bad++;
            $display("FAIL load_issue op=%b addr=%h want=10/00100", op, dataAddr);
        end
        wait_done(found);
        total++;
        if (!found) begin
            bad++;
            $display("FAIL load_done got=none want=pulse");
        end
        total++;
        if ({cpu_rvalid, cpu_err, op} !== 4'b1000 || cpu_rdata !== 64'h1122334455667788) begin
            bad++;
            $display("FAIL load_resp rvalid=%b err=%b op=%b rdata=%h want=1/0/00/1122334455667788",
                     cpu_rvalid, cpu_err, op, cpu_rdata);
        end
        @(negedge clk);
        total++;
        if ({cpu_done, cpu_rvalid} !== 2'b00 || cpu_rdata !== 64'h1122334455667788) begin
            bad++;
            $display("FAIL load_pulse done=%b rvalid=%b rdata=%h want=0/0/held",
                     cpu_done, cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] ea [3];
        logic [63:0] ed [3];
        logic [1:0]  iss_op [$];
        logic [17:0] iss_addr [$];
        logic [63:0] iss_data [$];
        int          ndone = 0;
        ea[0] = 18'h00008;
        ea[1] = 18'h00010;
        ea[2] = 18'h00018;
        for (int i = 0; i < 3; i++) ed[i] = {$urandom, $urandom};
        ctrl_en  = 1'b1;
        ctrl_lat = 1;
        fork
            begin
                send(1'b1, ea[0], ed[0]);
                send(1'b1, ea[1], ed[1]);
                total++;
                if (cpu_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_full_ready got=%b want=0", cpu_ready);
                end
                send(1'b1, ea[2], ed[2]);
            end
            begin
                logic [1:0] prev_op = 2'b00;
                for (int k = 0; k < 150 && ndone < 3; k++) begin
                    @(negedge clk);
                    if (op != 2'b00 && prev_op == 2'b00) begin
                        iss_op.push_back(op);
                        iss_addr.push_back(dataAddr);
                        iss_data.push_back(dataWrite);
                    end
                    if (cpu_done === 1'b1) begin
                        ndone++;
                        total++;
                        if ({cpu_rvalid, cpu_err, op} !== 4'b0000) begin
                            bad++;
                            $display("FAIL b2b_done rvalid=%b err=%b op=%b want=0/0/00",
                                     cpu_rvalid, cpu_err, op);
                        end
                    end
                    prev_op = op;
                end
            end
        join
        total++;
        if (ndone != 3 || iss_op.size() != 3) begin
            bad++;
            $display("FAIL b2b_count done=%0d issues=%0d want=3/3", ndone, iss_op.size());
        end
        for (int i = 0; i < iss_op.size() && i < 3; i++) begin
            total++;
            if (iss_op[i] !== 2'b01 || iss_addr[i] !== ea[i] || iss_data[i] !== ed[i]) begin
                bad++;
                $display("FAIL b2b_issue%0d op=%b addr=%h data=%h want=01/%h/%h",
                         i, iss_op[i], iss_addr[i], iss_data[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        bit          found;
        logic [63:0] v = {$urandom, $urandom};
        ctrl_en  = 1'b1;
        ctrl_lat = 2;
        send(1'b0, 18'h00003, 64'd0);
        total++;
        if (op !== 2'b00 || cpu_done !== 1'b0) begin
            bad++;
            $display("FAIL mis_early op=%b done=%b want=00/0", op, cpu_done);
        end
        @(negedge clk);
        total++;
        if ({cpu_done, cpu_err, cpu_rvalid, op} !== 5'b11000) begin
            bad++;
            $display("FAIL mis_resp done=%b err=%b rvalid=%b op=%b want=1/1/0/00",
                     cpu_done, cpu_err, cpu_rvalid, op);
        end
        @(negedge clk);
        total++;
        if ({cpu_done, cpu_err, op} !== 4'b0000) begin
            bad++;
            $display("FAIL mis_after done=%b err=%b op=%b want=0/0/00", cpu_done, cpu_err, op);
        end
        cmem[18'h00200] = v;
        send(1'b0, 18'h00200, 64'd0);
        wait_done(found);
        total++;
        if (!found || {cpu_rvalid, cpu_err} !== 2'b10 || cpu_rdata !== v) begin
            bad++;
            $display("FAIL mis_next found=%b rvalid=%b err=%b rdata=%h want=1/1/0/%h",
                     found, cpu_rvalid, cpu_err, cpu_rdata, v);
        end
    endtask

    task automatic test_timeout();
        logic [63:0] rd_before = cpu_rdata;
        int          ncyc      = 0;
        bit          found     = 1'b0;
        ctrl_en = 1'b0;
        send(1'b0, 18'h00040, 64'd0);
`ifdef MEM_BRIDGE_TIMEOUT_EN
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cpu_done === 1'b1) begin
                found = 1'b1;
                break;
            end
            if (op === 2'b10) ncyc++;
        end
        total++;
        if (!found || ncyc != TO) begin
            bad++;
            $display("FAIL timeout_len found=%b op_cycles=%0d want=1/%0d", found, ncyc, TO);
        end
        total++;
        if ({cpu_err, cpu_rvalid, op} !== 4'b1000 || cpu_rdata !== rd_before) begin
            bad++;
            $display("FAIL timeout_resp err=%b rvalid=%b op=%b rdata=%h want=1/0/00/%h",
                     cpu_err, cpu_rvalid, op, cpu_rdata, rd_before);
        end
`else
        @(negedge clk);
        for (int k = 0; k < 500; k++) begin
            if (op === 2'b10 && cpu_done === 1'b0) ncyc++;
            @(negedge clk);
        end
        total++;
        if (ncyc != 500) begin
            bad++;
            $display("FAIL timeout_hold op10_cycles=%0d want=500", ncyc);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_busy();
        bit          found;
        bit          quiet = 1'b1;
        int          n     = 0;
        logic [63:0] v     = {$urandom, $urandom};
        ctrl_en = 1'b0;
        send(1'b0, 18'h00080, 64'd0);
        send(1'b0, 18'h00088, 64'd0);
        while (op === 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (op !== 2'b10) begin
            bad++;
            $display("FAIL rstbusy_issue op=%b want=10", op);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({op, cpu_done, cpu_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL rstbusy_flush op=%b done=%b ready=%b want=00/0/0", op, cpu_done,
                     cpu_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstbusy_ready got=%b want=1", cpu_ready);
        end
        for (int k = 0; k < 6; k++) begin
            if (op !== 2'b00 || cpu_done !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL rstbusy_quiet got=activity want=idle");
        end
        ctrl_en         = 1'b1;
        ctrl_lat        = 2;
        cmem[18'h00090] = v;
        send(1'b0, 18'h00090, 64'd0);
        wait_done(found);
        total++;
        if (!found || cpu_rvalid !== 1'b1 || cpu_rdata !== v) begin
            bad++;
            $display("FAIL rstbusy_load found=%b rvalid=%b rdata=%h want=1/1/%h",
                     found, cpu_rvalid, cpu_rdata, v);
        end
    endtask

    task automatic test_random();
        int nreq  = 40;
        int ndone = 0;
        ctrl_en = 1'b1;
        fork
            begin
                for (int i = 0; i < nreq; i++) begin
                    req_t r;
                    repeat ($urandom % 3) @(negedge clk);
                    r.we   = 1'($urandom % 2);
                    r.addr = 18'h01000 + 18'(($urandom % 8) * 8);
                    if ($urandom % 5 == 0) r.addr[2:0] = 3'($urandom % 7 + 1);
                    r.wd     = {$urandom, $urandom};
                    ctrl_lat = $urandom % 5;
                    send(r.we, r.addr, r.wd);
                    exp_q.push_back(r);
                end
            end
            begin
                for (int k = 0; k < 3000 && ndone < nreq; k++) begin
                    @(negedge clk);
                    if (op !== 2'b00) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL rnd_issue op=%b with no request outstanding", op);
                        end else if (op !== (exp_q[0].we ? 2'b01 : 2'b10) ||
                                     dataAddr !== exp_q[0].addr || dataWrite !== exp_q[0].wd ||
                                     exp_q[0].addr[2:0] != 3'd0) begin
                            bad++;
                            $display("FAIL rnd_issue op=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                                     op, dataAddr, dataWrite, exp_q[0].we, exp_q[0].addr,
                                     exp_q[0].wd);
                        end
                    end
                    if (cpu_done === 1'b1) begin
                        ndone++;
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL rnd_done got=extra pulse want=none");
                        end else begin
                            req_t        e    = exp_q.pop_front();
                            bit          mis  = (e.addr[2:0] != 3'd0);
                            bit          rv   = !e.we && !mis;
                            logic [63:0] want = rmem.exists(e.addr) ? rmem[e.addr] : dflt(e.addr);
                            if (cpu_err !== mis || cpu_rvalid !== rv || op !== 2'b00 ||
                                (rv && cpu_rdata !== want)) begin
                                bad++;
                                $display("FAIL rnd_resp addr=%h err=%b rvalid=%b rdata=%h want=%b/%b/%h",
                                         e.addr, cpu_err, cpu_rvalid, cpu_rdata, mis, rv, want);
                            end
                            if (e.we && !mis) rmem[e.addr] = e.wd;
                        end
                    end else begin
                        total++;
                        if (cpu_rvalid !== 1'b0 || cpu_err !== 1'b0) begin
                            bad++;
                            $display("FAIL rnd_stray rvalid=%b err=%b want=0/0", cpu_rvalid, cpu_err);
                        end
                    end
                end
            end
        join
        total++;
        if (ndone != nreq || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rnd_count done=%0d left=%0d want=%0d/0", ndone, exp_q.size(), nreq);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
